pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Produces EX-operand forwarding selects.
- Detects load-use hazards and drives stalls and bubbles.
- Flushes wrong-path instructions on EX-resolved redirects (branch/jump).
- Freezes the whole pipeline while data memory is not ready.
- Sits beside the stage buffers and drives their write/flush enables and the PC write enable.

Parameters:
MEM_WAIT_MAX, 16, max cycles in MEM_WAIT before abort; range 1..255.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
id_rs, id_rt  in  5 each  source register fields of the instruction in ID
id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs/rt
ex_rs, ex_rt  in  5 each  source fields held in ID/EX
ex_write_addr  in  5  destination in ID/EX
ex_reg_write, ex_mem_read  in  1 each  ID/EX controls
ex_redirect  in  1  EX resolved a taken branch or jump
mem_write_addr  in  5  EX/MEM destination
mem_reg_write  in  1  EX/MEM control
mem_req  in  1  EX/MEM performs a load or store
dmem_ready  in  1  data memory completes the access this cycle
wb_write_addr  in  5  MEM/WB destination
wb_reg_write  in  1  MEM/WB control
pc_write, ifid_write, idex_write, exmem_write  out  1 each  stage enables
ifid_flush, idex_flush  out  1 each  load a bubble (all controls 0)
memwb_bubble  out  1  MEM/WB captures a bubble
fwd_a, fwd_b  out  2 each  EX operand select: 00 ID/EX, 01 EX/MEM alu_res, 10 MEM/WB write-back
mem_timeout  out  1  sticky abort flag
stall_count, flush_count  out  CNT_W each  performance counters

Behaviour:
- While reset is high:
  - All enables = 0, flushes = 0, memwb_bubble = 0, fwd = 00.
  - FSM = RUN; wait counter = 0; mem_timeout = 0; counters = 0.
- Forwarding (combinational, every cycle; same rule for fwd_b using ex_rt):
  - fwd_a = 01 if mem_reg_write and mem_write_addr != 0 and mem_write_addr == ex_rs.
  - Otherwise fwd_a = 10 if the same condition holds for the WB stage.
  - Otherwise fwd_a = 00.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- Load-use hazard (load_use): ex_mem_read and ex_reg_write and ex_write_addr != 0 and ((id_uses_rs and id_rs == ex_write_addr) or (id_uses_rt and id_rt == ex_write_addr)).
- FSM states: RUN and MEM_WAIT.
- freeze is true when either:
  - state is RUN and mem_req and !dmem_ready, or
  - state is MEM_WAIT and !dmem_ready and the wait counter is below MEM_WAIT_MAX.
- Output priority, highest first:
  1. freeze:
     - pc_write, ifid_write, idex_write, exmem_write = 0; memwb_bubble = 1.
     - No flushes. ex_redirect and load_use are ignored; they stay asserted because stages hold, and are serviced after release.
  2. ex_redirect:
     - All enables = 1; ifid_flush = 1, idex_flush = 1.
     - A simultaneous load_use is discarded, because its ID instruction is wrong-path.
  3. load_use:
     - pc_write = 0, ifid_write = 0, idex_flush = 1; idex_write, exmem_write = 1.
     - Exactly one stall cycle, after which the hazard clears.
  4. Otherwise: all enables = 1; no flush or bubble.
- Transitions:
  - RUN -> MEM_WAIT when mem_req and !dmem_ready; wait counter := 1.
  - MEM_WAIT + dmem_ready -> RUN, no freeze that cycle.
  - MEM_WAIT + !dmem_ready -> counter++.
  - Counter reaching MEM_WAIT_MAX with no ready:
    - mem_timeout := 1 (sticky until reset).
    - That cycle is released with memwb_bubble = 1 (access abandoned) -> RUN.
- Counters saturate at all-ones. stall_count += 1 per freeze or load_use cycle; flush_count += 1 per ex_redirect cycle not frozen.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: stall_count and flush_count are implemented as above.
- Undefined: no counter registers; both outputs are constant 0; all other behaviour is identical.

Test Plan:
1. EX/MEM rd=5 reg_write, MEM/WB rd=5, ex_rs=5, ex_rt=0 -> fwd_a=01, fwd_b=00. Same with EX/MEM rd=0 -> fwd_a=10.
2. Load-use:
   - Stimulus: ex_mem_read=1, ex_write_addr=8, id_rt=8, id_uses_rt=1.
   - Response: one cycle of pc_write=0, ifid_write=0, idex_flush=1; next cycle (load in MEM, bubble in EX) all enables 1. With HAZ_PERF_CNT_EN, stall_count=1.
3. mem_req=1, dmem_ready low 3 cycles then high -> freeze for 3 cycles (memwb_bubble=1); 4th cycle no freeze, state RUN; stall_count=3.
4. MEM_WAIT_MAX=4, dmem_ready held 0 -> freeze 4 cycles, release on the 5th with memwb_bubble=1; mem_timeout=1 and held until reset.
5. ex_redirect=1 together with load_use=1 -> ifid_flush=1, idex_flush=1, pc_write=1; no stall; flush_count=1. Same during freeze -> no flush until dmem_ready.
6. Assert reset for one cycle mid-MEM_WAIT -> next cycle state RUN, enables 0 during reset, counters 0, mem_timeout 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: EX forwarding selects,
// load-use stalls, redirect flushes and data-memory freeze. Perf counters need HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_write_addr,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_write_addr,
  input  logic             mem_reg_write,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic [4:0]       wb_write_addr,
  input  logic             wb_reg_write,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;
  logic       load_use_s, freeze_s, abort_s;

  // EX/MEM wins over MEM/WB; r0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       m_we,
    input logic [4:0] m_wa,
    input logic       w_we,
    input logic [4:0] w_wa
  );
    if (m_we && (m_wa != 5'd0) && (m_wa == src)) begin
      fwd_sel = 2'b01;
    end else if (w_we && (w_wa != 5'd0) && (w_wa == src)) begin
      fwd_sel = 2'b10;
    end else begin
      fwd_sel = 2'b00;
    end
  endfunction

  always_comb begin
    load_use_s = ex_mem_read && ex_reg_write && (ex_write_addr != 5'd0) &&
                 ((id_uses_rs && (id_rs == ex_write_addr)) ||
                  (id_uses_rt && (id_rt == ex_write_addr)));
    freeze_s   = 1'b0;
    abort_s    = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mem_req && !dmem_ready) begin
          freeze_s   = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          wait_cnt_d = 8'd0;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q < WAIT_MAX) begin
          freeze_s   = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          // Access abandoned: release the pipe with a bubble into MEM/WB.
          abort_s    = 1'b1;
          timeout_d  = 1'b1;
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    idex_write   = 1'b0;
    exmem_write  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
    mem_timeout  = 1'b0;
    if (reset) begin
      memwb_bubble = 1'b0;
    end else begin
      fwd_a       = fwd_sel(ex_rs, mem_reg_write, mem_write_addr, wb_reg_write, wb_write_addr);
      fwd_b       = fwd_sel(ex_rt, mem_reg_write, mem_write_addr, wb_reg_write, wb_write_addr);
      mem_timeout = timeout_q;
      if (freeze_s) begin
        memwb_bubble = 1'b1;
      end else begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        memwb_bubble = abort_s;
        // A redirect makes the ID instruction wrong-path, so its load-use is moot.
        if (ex_redirect) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use_s) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end else begin
          idex_flush = 1'b0;
        end
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= {CNT_W{1'b0}};
      flush_q <= {CNT_W{1'b0}};
    end else begin
      if ((freeze_s || (!ex_redirect && load_use_s)) && !(&stall_q)) begin
        stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (ex_redirect && !freeze_s && !(&flush_q)) begin
        flush_q <= flush_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stall_count = reset ? {CNT_W{1'b0}} : stall_q;
  assign flush_count = reset ? {CNT_W{1'b0}} : flush_q;
`else
  assign stall_count = {CNT_W{1'b0}};
  assign flush_count = {CNT_W{1'b0}};
`endif

endmodule
